// File: rtl/alu_op_sequencer_if.sv
// Handshake and datapath-control bundle between the instruction source,
// the control-step sequencer and the datapath enables.
interface alu_op_sequencer_if #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned OPC_W    = 5
);
   logic                start;
   logic                mem_ready;
   logic [31:0]         ir;

   logic                busy;
   logic                done;
   logic                illegal;
   logic [NUM_REGS-1:0] r_in;
   logic [NUM_REGS-1:0] r_out;
   logic                pc_out;
   logic                pc_in;
   logic                inc_pc;
   logic                mar_in;
   logic                read;
   logic                mdr_in;
   logic                mdr_out;
   logic                ir_in;
   logic                y_in;
   logic                z_in;
   logic                zlow_out;
   logic                zhigh_out;
   logic                hi_in;
   logic                lo_in;
   logic [OPC_W-1:0]    alu_op;

   modport master (
      output start, mem_ready, ir,
      input  busy, done, illegal, r_in, r_out,
      input  pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in,
      input  y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, alu_op
   );

   modport slave (
      input  start, mem_ready, ir,
      output busy, done, illegal, r_in, r_out,
      output pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in,
      output y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, alu_op
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// One-clock-per-step control sequencer: fetch (T0-T2) then register-register
// ALU execute (T3-T5) or MUL/DIV execute with HI/LO writeback (T3-T6).
module alu_op_sequencer #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned REG_AW   = 4,
   parameter int unsigned OPC_W    = 5,
   parameter int unsigned OPC_MAX  = 20,
   parameter int unsigned MUL_OPC  = 15,
   parameter int unsigned DIV_OPC  = 16
) (
   input  logic                clock,
   input  logic                clear,
   alu_op_sequencer_if.slave   bus
);

   localparam int unsigned OPC_LSB = 32 - OPC_W;
   localparam int unsigned RA_LSB  = OPC_LSB - REG_AW;
   localparam int unsigned RB_LSB  = RA_LSB - REG_AW;
   localparam int unsigned RC_LSB  = RB_LSB - REG_AW;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_T0   = 3'd1,
      S_T1   = 3'd2,
      S_T2   = 3'd3,
      S_T3   = 3'd4,
      S_T4   = 3'd5,
      S_T5   = 3'd6,
      S_T6   = 3'd7
   } state_e;

   // Instruction fields held from T3 exit for the remaining execute steps.
   typedef struct packed {
      logic [OPC_W-1:0]  opc;
      logic [REG_AW-1:0] ra;
      logic [REG_AW-1:0] rc;
   } fields_t;

   state_e  state_q, state_d;
   fields_t fld_q, fld_d;

   logic [OPC_W-1:0]  ir_opc;
   logic [REG_AW-1:0] ir_ra;
   logic [REG_AW-1:0] ir_rb;
   logic [REG_AW-1:0] ir_rc;
   logic              ir_illegal;
   logic              hilo_op;
   logic              unused_ir_lo;

   assign ir_opc = bus.ir[OPC_LSB +: OPC_W];
   assign ir_ra  = bus.ir[RA_LSB +: REG_AW];
   assign ir_rb  = bus.ir[RB_LSB +: REG_AW];
   assign ir_rc  = bus.ir[RC_LSB +: REG_AW];
   assign unused_ir_lo = ^bus.ir[RC_LSB-1:0];

   assign ir_illegal = (32'(ir_opc) > OPC_MAX)
                    || (32'(ir_ra) >= NUM_REGS)
                    || (32'(ir_rb) >= NUM_REGS)
                    || (32'(ir_rc) >= NUM_REGS);

   assign hilo_op = (fld_q.opc == OPC_W'(MUL_OPC)) || (fld_q.opc == OPC_W'(DIV_OPC));

   // Next-state and field latch.
   always_comb begin
      state_d = state_q;
      fld_d   = fld_q;
      case (state_q)
         S_IDLE: if (bus.start) state_d = S_T0;
         S_T0:   state_d = S_T1;
         S_T1:   if (bus.mem_ready) state_d = S_T2;
         S_T2:   state_d = S_T3;
         S_T3: begin
            if (ir_illegal) begin
               state_d = S_IDLE;
            end else begin
               state_d   = S_T4;
               fld_d.opc = ir_opc;
               fld_d.ra  = ir_ra;
               fld_d.rc  = ir_rc;
            end
         end
         S_T4:   state_d = S_T5;
         S_T5: begin
            if (hilo_op)        state_d = S_T6;
            else if (bus.start) state_d = S_T0;
            else                state_d = S_IDLE;
         end
         S_T6:   state_d = bus.start ? S_T0 : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q <= S_IDLE;
         fld_q   <= '0;
      end else begin
         state_q <= state_d;
         fld_q   <= fld_d;
      end
   end

   // Control strobes are a pure decode of the step register and held fields;
   // only T3 looks at ir, which the datapath holds stable through that step.
   always_comb begin
      bus.busy      = (state_q != S_IDLE);
      bus.done      = 1'b0;
      bus.illegal   = 1'b0;
      bus.r_in      = '0;
      bus.r_out     = '0;
      bus.pc_out    = 1'b0;
      bus.pc_in     = 1'b0;
      bus.inc_pc    = 1'b0;
      bus.mar_in    = 1'b0;
      bus.read      = 1'b0;
      bus.mdr_in    = 1'b0;
      bus.mdr_out   = 1'b0;
      bus.ir_in     = 1'b0;
      bus.y_in      = 1'b0;
      bus.z_in      = 1'b0;
      bus.zlow_out  = 1'b0;
      bus.zhigh_out = 1'b0;
      bus.hi_in     = 1'b0;
      bus.lo_in     = 1'b0;
      bus.alu_op    = '0;
      case (state_q)
         S_T0: begin
            bus.pc_out = 1'b1;
            bus.mar_in = 1'b1;
            bus.inc_pc = 1'b1;
         end
         S_T1: begin
            bus.read   = 1'b1;
            bus.mdr_in = 1'b1;
         end
         S_T2: begin
            bus.mdr_out = 1'b1;
            bus.ir_in   = 1'b1;
         end
         S_T3: begin
            if (ir_illegal) begin
               bus.illegal = 1'b1;
            end else begin
               bus.r_out = NUM_REGS'(1) << ir_rb;
               bus.y_in  = 1'b1;
            end
         end
         S_T4: begin
            bus.r_out  = NUM_REGS'(1) << fld_q.rc;
            bus.alu_op = fld_q.opc;
            bus.z_in   = 1'b1;
         end
         S_T5: begin
            bus.zlow_out = 1'b1;
            if (hilo_op) begin
               bus.lo_in = 1'b1;
            end else begin
               bus.r_in = NUM_REGS'(1) << fld_q.ra;
               bus.done = 1'b1;
            end
         end
         S_T6: begin
            bus.zhigh_out = 1'b1;
            bus.hi_in     = 1'b1;
            bus.done      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
